// File: rtl/rdo_pkg.sv
// Shared definitions for the readout arbiter: register map, FSM states, source IDs.
// Source IDs double as the readout mux select encoding.
package rdo_pkg;

  localparam logic [7:0] ADDR_STATUS      = 8'h00;
  localparam logic [7:0] ADDR_CTRL        = 8'h01;
  localparam logic [7:0] ADDR_TIMEOUT     = 8'h02;
  localparam logic [7:0] ADDR_PAR_EVTCNT  = 8'h03;
  localparam logic [7:0] ADDR_CTRL_EVTCNT = 8'h04;

  localparam logic [15:0] REG_UNMAPPED = 16'hF001;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PAR  = 2'd1,
    SRC_CTRL = 2'd2
  } src_e;

endpackage

// File: rtl/rdo_arbiter_if.sv
// Register bus, two readout sources and the shared readout stream of the arbiter.
// slave = arbiter side, master = the surrounding logic driving it.
interface rdo_arbiter_if;
  logic        reg_we_i;
  logic [7:0]  reg_addr_i;
  logic [15:0] reg_data_i;
  logic [15:0] reg_data_o;

  logic        par_req_i;
  logic        par_gnt_o;
  logic [7:0]  par_data_i;
  logic        par_we_i;
  logic        par_evtdone_i;

  logic        ctrl_req_i;
  logic        ctrl_gnt_o;
  logic [7:0]  ctrl_data_i;
  logic        ctrl_we_i;
  logic        ctrl_evtdone_i;

  logic [7:0]  rdo_data_o;
  logic        rdo_we_o;
  logic        rdo_evtdone_o;
  logic        rdo_busy_o;

  modport slave (
    input  reg_we_i, reg_addr_i, reg_data_i,
    input  par_req_i, par_data_i, par_we_i, par_evtdone_i,
    input  ctrl_req_i, ctrl_data_i, ctrl_we_i, ctrl_evtdone_i,
    output reg_data_o, par_gnt_o, ctrl_gnt_o,
    output rdo_data_o, rdo_we_o, rdo_evtdone_o, rdo_busy_o
  );

  modport master (
    output reg_we_i, reg_addr_i, reg_data_i,
    output par_req_i, par_data_i, par_we_i, par_evtdone_i,
    output ctrl_req_i, ctrl_data_i, ctrl_we_i, ctrl_evtdone_i,
    input  reg_data_o, par_gnt_o, ctrl_gnt_o,
    input  rdo_data_o, rdo_we_o, rdo_evtdone_o, rdo_busy_o
  );
endinterface

// File: rtl/rdo_evtcnt.sv
// 16-bit wrapping event counter; count visible 1 cycle after inc_i; no backpressure.
// Synchronous clear takes priority over a coincident increment.
module rdo_evtcnt (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  input  logic        clr_i,
  output logic [15:0] cnt_o
);

  logic [15:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (inc_i) cnt_q <= cnt_q + 16'd1;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/rdo_arbiter.sv
// Event-level arbiter of PAR/CTRL onto one readout stream; grant 1 cycle after request, data path combinational.
// No backpressure: the owner streams freely, a watchdog aborts stalled events.
module rdo_arbiter
  import rdo_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_RST = 16'd0
) (
  input logic          clk_i,
  input logic          rst_i,
  rdo_arbiter_if.slave bus
);

  state_e      state_q;
  src_e        owner_q, last_q, win;
  logic        enable_q, mode_q, tmo_q;
  logic [15:0] timeout_q, idle_q, idle_now;
  logic        par_gnt_q, ctrl_gnt_q;
  logic [7:0]  own_data;
  logic        own_we, own_done;
  logic        in_grant, evt_done, tmo_hit;
  logic [15:0] par_cnt, ctrl_cnt;

  always_comb begin
    own_data = '0;
    own_we   = 1'b0;
    own_done = 1'b0;
    case (owner_q)
      SRC_PAR: begin
        own_data = bus.par_data_i;
        own_we   = bus.par_we_i;
        own_done = bus.par_evtdone_i;
      end
      SRC_CTRL: begin
        own_data = bus.ctrl_data_i;
        own_we   = bus.ctrl_we_i;
        own_done = bus.ctrl_evtdone_i;
      end
      default: ;
    endcase
  end

  // Idle count includes the current cycle, so an abort lands TIMEOUT cycles after the last byte.
  assign in_grant = (state_q == ST_GRANT);
  assign idle_now = own_we ? 16'd0 : idle_q + 16'd1;
  assign tmo_hit  = in_grant && (timeout_q != 16'd0) && (idle_now >= timeout_q);
  assign evt_done = in_grant && own_we && own_done;

  assign bus.rdo_data_o    = in_grant ? own_data : 8'd0;
  assign bus.rdo_we_o      = in_grant && own_we && !tmo_hit;
  assign bus.rdo_evtdone_o = in_grant && (own_done || tmo_hit);
  assign bus.rdo_busy_o    = (state_q != ST_IDLE);
  assign bus.par_gnt_o     = par_gnt_q;
  assign bus.ctrl_gnt_o    = ctrl_gnt_q;

  always_comb begin
    win = SRC_NONE;
    if (bus.par_req_i && bus.ctrl_req_i)
      win = (mode_q || last_q != SRC_PAR) ? SRC_PAR : SRC_CTRL;
    else if (bus.par_req_i)
      win = SRC_PAR;
    else if (bus.ctrl_req_i)
      win = SRC_CTRL;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      owner_q    <= SRC_NONE;
      last_q     <= SRC_CTRL;
      idle_q     <= '0;
      par_gnt_q  <= 1'b0;
      ctrl_gnt_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          idle_q <= '0;
          if (enable_q && win != SRC_NONE) begin
            owner_q    <= win;
            par_gnt_q  <= (win == SRC_PAR);
            ctrl_gnt_q <= (win == SRC_CTRL);
            state_q    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          idle_q <= idle_now;
          if (evt_done || tmo_hit) begin
            par_gnt_q  <= 1'b0;
            ctrl_gnt_q <= 1'b0;
            state_q    <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          last_q  <= owner_q;
          owner_q <= SRC_NONE;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      enable_q  <= 1'b0;
      mode_q    <= 1'b0;
      tmo_q     <= 1'b0;
      timeout_q <= TIMEOUT_RST;
    end else begin
      if (bus.reg_we_i && bus.reg_addr_i == ADDR_CTRL) begin
        enable_q <= bus.reg_data_i[0];
        mode_q   <= bus.reg_data_i[1];
      end
      if (bus.reg_we_i && bus.reg_addr_i == ADDR_TIMEOUT)
        timeout_q <= bus.reg_data_i;
      // A fresh abort outranks a coincident write-1-clear so it is never lost.
      if (tmo_hit)
        tmo_q <= 1'b1;
      else if (bus.reg_we_i && bus.reg_addr_i == ADDR_CTRL && bus.reg_data_i[2])
        tmo_q <= 1'b0;
    end
  end

  rdo_evtcnt u_par_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (evt_done && owner_q == SRC_PAR),
    .clr_i (bus.reg_we_i && bus.reg_addr_i == ADDR_PAR_EVTCNT),
    .cnt_o (par_cnt)
  );

  rdo_evtcnt u_ctrl_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (evt_done && owner_q == SRC_CTRL),
    .clr_i (bus.reg_we_i && bus.reg_addr_i == ADDR_CTRL_EVTCNT),
    .cnt_o (ctrl_cnt)
  );

  always_comb begin
    case (bus.reg_addr_i)
      ADDR_STATUS:      bus.reg_data_o = {10'b0, tmo_q, owner_q, state_q, enable_q};
      ADDR_CTRL:        bus.reg_data_o = {14'b0, mode_q, enable_q};
      ADDR_TIMEOUT:     bus.reg_data_o = timeout_q;
      ADDR_PAR_EVTCNT:  bus.reg_data_o = par_cnt;
      ADDR_CTRL_EVTCNT: bus.reg_data_o = ctrl_cnt;
      default:          bus.reg_data_o = REG_UNMAPPED;
    endcase
  end

endmodule

// File: tb/tb_rdo_arbiter.sv
// Directed bench for rdo_arbiter: priority, round-robin, watchdog, enable, counters, async reset.
// Inputs change 1 ns after the rising edge; outputs are sampled 3 ns after it.
module tb_rdo_arbiter;

  localparam logic [15:0] TMO_RST = 16'd200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  rdo_arbiter_if b ();

  rdo_arbiter #(.TIMEOUT_RST(TMO_RST)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(input logic [7:0] a, input logic [15:0] d);
    b.reg_we_i   = 1'b1;
    b.reg_addr_i = a;
    b.reg_data_i = d;
    tick();
    b.reg_we_i   = 1'b0;
  endtask

  task automatic reg_rd(input logic [7:0] a, output logic [15:0] d);
    b.reg_addr_i = a;
    #1;
    d = b.reg_data_o;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [15:0] exp);
    logic [15:0] v;
    reg_rd(a, v);
    chk(tag, v, exp);
  endtask

  task automatic par_drive(input logic we, input logic [7:0] d, input logic done);
    b.par_we_i = we; b.par_data_i = d; b.par_evtdone_i = done;
  endtask

  task automatic ctrl_drive(input logic we, input logic [7:0] d, input logic done);
    b.ctrl_we_i = we; b.ctrl_data_i = d; b.ctrl_evtdone_i = done;
  endtask

  logic [15:0] v;
  logic [1:0]  g;

  initial begin
    b.reg_we_i = 0; b.reg_addr_i = 0; b.reg_data_i = 0;
    b.par_req_i = 0; b.ctrl_req_i = 0;
    par_drive(0, 8'h00, 0);
    ctrl_drive(0, 8'h00, 0);

    // Reset state
    #12;
    chk("rst_busy", {15'd0, b.rdo_busy_o}, 16'd0);
    chk("rst_gnt", {14'd0, b.ctrl_gnt_o, b.par_gnt_o}, 16'd0);
    chk("rst_rdo", {6'd0, b.rdo_we_o, b.rdo_evtdone_o, b.rdo_data_o}, 16'd0);
    rd_chk("rst_status", 8'h00, 16'h0000);
    rd_chk("rst_ctrl", 8'h01, 16'h0000);
    rd_chk("rst_timeout", 8'h02, TMO_RST);
    rd_chk("rst_parcnt", 8'h03, 16'h0000);
    rst = 1'b0;
    tick();

    // Fixed priority: both request together, PAR wins
    reg_wr(8'h01, 16'h0003);
    b.par_req_i = 1; b.ctrl_req_i = 1;
    tick();
    b.par_req_i = 0;
    par_drive(1, 8'hA0, 0);
    ctrl_drive(1, 8'h55, 1);
    #2;
    chk("prio_gnt", {14'd0, b.ctrl_gnt_o, b.par_gnt_o}, 16'h0001);
    chk("prio_busy", {15'd0, b.rdo_busy_o}, 16'd1);
    rd_chk("prio_status", 8'h00, 16'h000B);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        tick();
        par_drive(1, 8'hA0 + 8'(i), i == 3);
        #2;
      end
      chk("prio_byte", {6'd0, b.rdo_we_o, b.rdo_evtdone_o, b.rdo_data_o},
          {6'd0, 1'b1, i == 3, 8'hA0 + 8'(i)});
    end
    tick();
    par_drive(0, 8'h00, 0);
    ctrl_drive(0, 8'h00, 0);
    #2;
    chk("rel_gnt", {14'd0, b.ctrl_gnt_o, b.par_gnt_o}, 16'h0000);
    chk("rel_rdo", {6'd0, b.rdo_we_o, b.rdo_evtdone_o, b.rdo_data_o}, 16'h0000);
    chk("rel_busy", {15'd0, b.rdo_busy_o}, 16'd1);
    rd_chk("prio_parcnt", 8'h03, 16'd1);
    tick();
    #2;
    chk("idle_gnt", {14'd0, b.ctrl_gnt_o, b.par_gnt_o}, 16'h0000);
    chk("idle_busy", {15'd0, b.rdo_busy_o}, 16'd0);
    tick();
    b.ctrl_req_i = 0;
    ctrl_drive(1, 8'h77, 1);
    #2;
    chk("ctrl_gnt_3cyc", {14'd0, b.ctrl_gnt_o, b.par_gnt_o}, 16'h0002);
    chk("ctrl_byte", {6'd0, b.rdo_we_o, b.rdo_evtdone_o, b.rdo_data_o}, 16'h0377);
    tick();
    ctrl_drive(0, 8'h00, 0);
    tick();
    rd_chk("ctrl_cnt1", 8'h04, 16'd1);

    // Round-robin with both requests held
    reg_wr(8'h01, 16'h0001);
    reg_wr(8'h03, 16'h0000);
    reg_wr(8'h04, 16'h0000);
    b.par_req_i = 1; b.ctrl_req_i = 1;
    for (int e = 0; e < 6; e++) begin
      g = 2'b00;
      for (int w = 0; w < 8; w++) begin
        tick();
        #2;
        g = {b.ctrl_gnt_o, b.par_gnt_o};
        if (g != 2'b00) break;
      end
      chk("rr_order", {14'd0, g}, (e % 2 == 0) ? 16'h0001 : 16'h0002);
      if (e == 5) begin b.par_req_i = 0; b.ctrl_req_i = 0; end
      if (g[0]) par_drive(1, 8'(e), 1);
      else      ctrl_drive(1, 8'(e), 1);
      tick();
      par_drive(0, 8'h00, 0);
      ctrl_drive(0, 8'h00, 0);
    end
    tick();
    tick();
    rd_chk("rr_parcnt", 8'h03, 16'd3);
    rd_chk("rr_ctrlcnt", 8'h04, 16'd3);

    // Watchdog abort 5 cycles after last byte
    reg_wr(8'h02, 16'd5);
    b.ctrl_req_i = 1;
    tick();
    b.ctrl_req_i = 0;
    ctrl_drive(1, 8'h3C, 0);
    #2;
    chk("wd_gnt", {14'd0, b.ctrl_gnt_o, b.par_gnt_o}, 16'h0002);
    chk("wd_byte", {6'd0, b.rdo_we_o, b.rdo_evtdone_o, b.rdo_data_o}, 16'h023C);
    tick();
    ctrl_drive(0, 8'h00, 0);
    for (int k = 1; k <= 5; k++) begin
      #2;
      chk("wd_evtdone", {14'd0, b.rdo_we_o, b.rdo_evtdone_o}, (k == 5) ? 16'h0001 : 16'h0000);
      tick();
    end
    rd_chk("wd_status", 8'h00, 16'h0035);
    tick();
    rd_chk("wd_ctrlcnt", 8'h04, 16'd3);
    reg_wr(8'h01, 16'h0005);
    rd_chk("wd_clr_status", 8'h00, 16'h0001);
    rd_chk("wd_clr_ctrl", 8'h01, 16'h0001);
    reg_wr(8'h02, 16'd0);

    // Enable cleared mid-event: event completes, no new grant
    b.par_req_i = 1;
    tick();
    par_drive(1, 8'h11, 0);
    b.reg_we_i = 1; b.reg_addr_i = 8'h01; b.reg_data_i = 16'h0000;
    tick();
    b.reg_we_i = 0;
    par_drive(1, 8'h22, 1);
    #2;
    chk("en_gnt_hold", {15'd0, b.par_gnt_o}, 16'd1);
    chk("en_done", {6'd0, b.rdo_we_o, b.rdo_evtdone_o, b.rdo_data_o}, 16'h0322);
    tick();
    par_drive(0, 8'h00, 0);
    for (int k = 0; k < 4; k++) tick();
    #2;
    chk("en_no_gnt", {14'd0, b.ctrl_gnt_o, b.par_gnt_o}, 16'h0000);
    chk("en_no_busy", {15'd0, b.rdo_busy_o}, 16'd0);
    rd_chk("en_parcnt", 8'h03, 16'd4);
    b.par_req_i = 0;
    rd_chk("unmapped_10", 8'h10, 16'hF001);
    rd_chk("unmapped_ff", 8'hFF, 16'hF001);
    tick();

    // Counter clear coinciding with evtdone
    reg_wr(8'h01, 16'h0001);
    b.par_req_i = 1;
    tick();
    b.par_req_i = 0;
    par_drive(1, 8'h99, 1);
    b.reg_we_i = 1; b.reg_addr_i = 8'h03; b.reg_data_i = 16'h1234;
    tick();
    b.reg_we_i = 0;
    par_drive(0, 8'h00, 0);
    rd_chk("clr_wins", 8'h03, 16'd0);
    tick();

    // Counter wrap
    force dut.u_par_cnt.cnt_q = 16'hFFFF;
    #1;
    release dut.u_par_cnt.cnt_q;
    rd_chk("wrap_pre", 8'h03, 16'hFFFF);
    b.par_req_i = 1;
    tick();
    b.par_req_i = 0;
    par_drive(1, 8'h01, 1);
    tick();
    par_drive(0, 8'h00, 0);
    rd_chk("wrap_zero", 8'h03, 16'h0000);
    tick();

    // Async reset during GRANT
    reg_wr(8'h02, 16'd7);
    b.par_req_i = 1;
    tick();
    par_drive(1, 8'h5A, 0);
    #2;
    chk("mid_we", {15'd0, b.rdo_we_o}, 16'd1);
    rst = 1'b1;
    #1;
    chk("arst_gnt", {15'd0, b.par_gnt_o}, 16'd0);
    chk("arst_we", {15'd0, b.rdo_we_o}, 16'd0);
    chk("arst_busy", {15'd0, b.rdo_busy_o}, 16'd0);
    rd_chk("arst_status", 8'h00, 16'h0000);
    rd_chk("arst_ctrl", 8'h01, 16'h0000);
    rd_chk("arst_timeout", 8'h02, TMO_RST);
    rd_chk("arst_parcnt", 8'h03, 16'h0000);
    rd_chk("arst_ctrlcnt", 8'h04, 16'h0000);
    b.par_req_i = 0;
    par_drive(0, 8'h00, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rdo_arbiter.md
Name: rdo_arbiter

Overview:
- Event-level arbiter sharing the single readout stream between the parallel-port readout source (PAR) and the control-port readout source (CTRL).
- Grants one source at a time for a whole event; forwards that source's byte stream to the readout FIFO/USB path; releases on event end or timeout.
- Configured and monitored through the standard 8-bit-address / 16-bit-data register bus.

Parameters:
- TIMEOUT_RST, 16'd0, reset value of the TIMEOUT register (0 = watchdog disabled).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; asynchronous, active-high
- reg_we_i  in  1  register write strobe
- reg_addr_i  in  8  register address
- reg_data_i  in  16  register write data
- reg_data_o  out  16  register read data (combinational from reg_addr_i)
- par_req_i  in  1  PAR has an event ready
- par_gnt_o  out  1  PAR owns the stream
- par_data_i  in  8  PAR byte
- par_we_i  in  1  PAR byte valid
- par_evtdone_i  in  1  PAR last byte of event (qualified by par_we_i)
- ctrl_req_i, ctrl_gnt_o, ctrl_data_i, ctrl_we_i, ctrl_evtdone_i  as PAR, for CTRL
- rdo_data_o  out  8  forwarded byte
- rdo_we_o  out  1  forwarded byte valid
- rdo_evtdone_o  out  1  event end (real or timeout abort)
- rdo_busy_o  out  1  high while state != IDLE

Behaviour:
- Registers:
  - 0x00 STATUS (RO): {10'b0, tmo_flag, owner[1:0], state[1:0], enable}.
  - 0x01 CTRL (RW): bit0 enable, bit1 mode (0 = round-robin, 1 = fixed priority PAR), bit2 write-1-clears tmo_flag (reads 0). Reset value 0.
  - 0x02 TIMEOUT (RW, 16 bit).
  - 0x03 PAR_EVTCNT, 0x04 CTRL_EVTCNT (RO; any write clears to 0).
  - Unmapped addresses read 16'hF001.
- Reset (async): state = IDLE, gnt = 0, owner = NONE (0), last = CTRL (so PAR wins the first round-robin tie), counters = 0, tmo_flag = 0, enable = 0.
- Reset output values: rdo_* = 0 and busy = 0.
- State machine (registered):
  - IDLE:
    - Stays in IDLE if enable = 0 or no request is present.
    - Otherwise picks a winner:
      - Only one request present: that requester wins.
      - Both present, mode = 1: PAR wins.
      - Both present, mode = 0: the source != last wins.
    - On a winner: owner <= winner, next state GRANT.
    - Grant is visible the cycle after the request was sampled (1-cycle latency).
  - GRANT:
    - gnt_o of the owner is high.
    - rdo_data/we/evtdone = owner inputs, combinationally.
    - Owner we & evtdone -> RELEASE; the corresponding EVTCNT increments.
  - Watchdog in GRANT:
    - Idle counter increments each cycle owner we = 0 and clears on we = 1.
    - If TIMEOUT != 0 and the idle counter reaches TIMEOUT, then in that same cycle: rdo_evtdone_o = 1, rdo_we_o = 0, tmo_flag <= 1, next state RELEASE.
    - Aborted events are not counted.
  - RELEASE: one cycle with gnt = 0 and rdo_* = 0; last <= owner; owner <= NONE; next state IDLE.
- Outside GRANT: rdo_data_o = 0, rdo_we_o = 0, rdo_evtdone_o = 0.
- The non-owner's inputs are always ignored.
- Clearing enable mid-event does not abort the event; it only blocks new grants.
- Counters are 16-bit and wrap 0xFFFF -> 0x0000. A write-clear in the same cycle as an increment: clear wins (result 0).
- Writing TIMEOUT during GRANT takes effect on the next compare cycle.
- Minimum event-to-event gap: 2 cycles (RELEASE + IDLE).

Decomposition:
- Shared package rdo_pkg: register addresses (STATUS, CTRL, TIMEOUT, PAR_EVTCNT, CTRL_EVTCNT), state encodings (IDLE = 0, GRANT = 1, RELEASE = 2), source IDs (NONE = 0, PAR = 1, CTRL = 2; these match the readout mux select encoding), unmapped read value 16'hF001.
- Sub-module rdo_evtcnt: 16-bit event counter with increment, synchronous clear and async reset; instantiated twice.

Test Plan:
- Priority/single source: enable = 1, mode = 1; assert par_req and ctrl_req together at cycle N -> par_gnt_o = 1 at N+1 and ctrl_gnt_o stays 0. PAR sends 4 bytes, last with evtdone -> rdo_* mirrors exactly those 4 bytes; PAR_EVTCNT = 1; ctrl_gnt rises 3 cycles after evtdone.
- Round-robin fairness: mode = 0, both requests held for 6 events -> grant order PAR, CTRL, PAR, CTRL, PAR, CTRL; both counters read 3.
- Watchdog: TIMEOUT = 5; CTRL granted and sends 1 byte, then we = 0 -> rdo_evtdone_o = 1 with rdo_we_o = 0 exactly 5 cycles after the last byte. STATUS bit5 = 1; CTRL_EVTCNT unchanged. Writing CTRL bit2 = 1 clears bit5.
- Enable/unmapped: enable cleared mid-event -> event completes, then no new grant despite par_req = 1. Read address 0x10 -> 16'hF001.
- Reset mid-event: assert rst_i asynchronously during GRANT -> gnt_o, rdo_we_o and busy go 0 immediately; registers read 0 except TIMEOUT = TIMEOUT_RST.
- Counter wrap/clear: force PAR_EVTCNT to 0xFFFF via 65535 events (or a backdoor force) -> the next event gives 0x0000. A write to 0x03 coinciding with evtdone -> counter reads 0.
